nand_resp_checker: RTL and testbench

Clocked self-checking response monitor for a single 2-input NAND gate under test (`nand00`-class DUT). It is the observing end of the gate stimulus interface: a bench or on-board test fixture drives `a`/`b` into the gate, and this block watches `a`, `b` and `q`. After each input change it waits a settle window, checks `q == ~(a & b)`, and flags output glitches while the inputs are stable. It keeps pass/fail counters for readout.

---
 rtl/nandy_test_pkg.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/nand_resp_checker.sv | 141 ++++++++++++++
 tb/tb_nand_resp_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nandy_test_pkg.sv
// Shared types for the NAND gate test fixtures: monitor FSM states and the
// bit layout of the captured failure vector.
package nandy_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

  localparam int unsigned FV_W = 3;
  localparam int unsigned FV_A = 2;
  localparam int unsigned FV_B = 1;
  localparam int unsigned FV_Q = 0;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nand_resp_checker.sv
// Response monitor for a 2-input NAND under test: waits for the inputs to
// settle, checks q against ~(a&b), flags idle glitches and keeps counters.
module nand_resp_checker
  import nandy_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             q,
  input  logic             enable,
  input  logic             clear,
  output logic             check_done,
  output logic             check_fail,
  output logic             fail_sticky,
  output logic [FV_W-1:0]  fail_vec,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] error_count,
  output logic             busy
);

  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic a_s, b_s, q_s;

  sync2 u_sync_a (.clk(clk), .rst_n(rst_n), .d_i(a), .q_o(a_s));
  sync2 u_sync_b (.clk(clk), .rst_n(rst_n), .d_i(b), .q_o(b_s));
  sync2 u_sync_q (.clk(clk), .rst_n(rst_n), .d_i(q), .q_o(q_s));

  state_e          state_q, state_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  logic [1:0]      ab_prev_q;
  logic            q_prev_q;
  logic            en_q;

  logic             sticky_q, sticky_d;
  logic [FV_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic in_chg, chg_eff, glitch, in_check, mismatch;

  // Enable rising is treated as an input change so the steady state gets checked.
  assign in_chg   = ({a_s, b_s} != ab_prev_q);
  assign chg_eff  = in_chg | (enable & ~en_q);
  assign in_check = (state_q == ST_CHECK);
  assign mismatch = in_check & (q_s != ~(a_s & b_s));
  assign glitch   = (state_q == ST_IDLE) & enable & ~chg_eff & (q_s != q_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ab_prev_q <= 2'b00;
      q_prev_q  <= 1'b0;
      en_q      <= 1'b0;
      sticky_q  <= 1'b0;
      vec_q     <= '0;
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ab_prev_q <= {a_s, b_s};
      q_prev_q  <= q_s;
      en_q      <= enable;
      sticky_q  <= sticky_d;
      vec_q     <= vec_d;
      chk_cnt_q <= chk_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Settle-window FSM; any input change restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && chg_eff) begin
          state_d = ST_SETTLE;
          cnt_d   = SC_LOAD;
        end
      end
      ST_SETTLE: begin
        if (chg_eff) begin
          cnt_d = SC_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - SC_W'(1);
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
    end
  end

  // Result bookkeeping; clear takes priority over any update.
  always_comb begin
    sticky_d  = sticky_q;
    vec_d     = vec_q;
    chk_cnt_d = chk_cnt_q;
    err_cnt_d = err_cnt_q;
    if (in_check && (chk_cnt_q != CNT_MAX)) begin
      chk_cnt_d = chk_cnt_q + CNT_W'(1);
    end
    if (mismatch || glitch) begin
      sticky_d     = 1'b1;
      vec_d[FV_A]  = a_s;
      vec_d[FV_B]  = b_s;
      vec_d[FV_Q]  = q_s;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
    if (clear) begin
      sticky_d  = 1'b0;
      vec_d     = '0;
      chk_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  assign check_done  = in_check;
  assign check_fail  = mismatch;
  assign busy        = (state_q != ST_IDLE);
  assign fail_sticky = sticky_q;
  assign fail_vec    = vec_q;
  assign check_count = chk_cnt_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_nand_resp_checker.sv
// Directed bench for nand_resp_checker: a deadline-based reference model is
// compared every cycle against two instances (16-bit and 2-bit counters).
module tb_nand_resp_checker;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, b, q, enable, clear;

  logic        done1, fail1, sticky1, busy1;
  logic [2:0]  vec1;
  logic [15:0] cc1, ec1;
  logic        done2, fail2, sticky2, busy2;
  logic [2:0]  vec2;
  logic [1:0]  cc2, ec2;

  nand_resp_checker #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .q(q), .enable(enable), .clear(clear),
    .check_done(done1), .check_fail(fail1), .fail_sticky(sticky1), .fail_vec(vec1),
    .check_count(cc1), .error_count(ec1), .busy(busy1)
  );

  nand_resp_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .q(q), .enable(enable), .clear(clear),
    .check_done(done2), .check_fail(fail2), .fail_sticky(sticky2), .fail_vec(vec2),
    .check_count(cc2), .error_count(ec2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Reference model: a check is due S+1 cycles after the last change of the
  // synchronized inputs; raw inputs reach the monitor two cycles late.
  int       cyc = 0;
  int       check_at = -1;
  logic [2:0] s1, s2;
  logic [1:0] pab;
  logic     pqs, pen;
  int       m_c16, m_e16, m_c2, m_e2;
  logic     m_sticky;
  logic [2:0] m_vec;
  logic     as_m, bs_m, qs_m, chg, due, mis;
  int       ndone = 0;
  int       nfailp = 0;

  task automatic model_reset();
    check_at = -1;
    s1 = 3'b000; s2 = 3'b000; pab = 2'b00; pqs = 1'b0; pen = 1'b0;
    m_c16 = 0; m_e16 = 0; m_c2 = 0; m_e2 = 0; m_sticky = 1'b0; m_vec = 3'b000;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    as_m = s2[2]; bs_m = s2[1]; qs_m = s2[0];
    due  = (check_at == cyc);
    mis  = due && (qs_m != !(as_m && bs_m));

    chk("check_done",  int'(done1),   int'(due));
    chk("check_fail",  int'(fail1),   int'(mis));
    chk("busy",        int'(busy1),   int'(check_at >= 0));
    chk("fail_sticky", int'(sticky1), int'(m_sticky));
    chk("fail_vec",    int'(vec1),    int'(m_vec));
    chk("check_count", int'(cc1),     m_c16);
    chk("error_count", int'(ec1),     m_e16);
    chk("w2 check_done",  int'(done2),   int'(due));
    chk("w2 check_fail",  int'(fail2),   int'(mis));
    chk("w2 fail_sticky", int'(sticky2), int'(m_sticky));
    chk("w2 check_count", int'(cc2),     m_c2);
    chk("w2 error_count", int'(ec2),     m_e2);
    if (done1 === 1'b1) ndone++;
    if (fail1 === 1'b1) nfailp++;

    if (rst_n) begin
      chg = ({as_m, bs_m} != pab) || (enable && !pen);
      if (due) begin
        m_c16 = sat_inc(m_c16, 65535);
        m_c2  = sat_inc(m_c2, 3);
        if (mis) begin
          m_e16 = sat_inc(m_e16, 65535); m_e2 = sat_inc(m_e2, 3);
          m_sticky = 1'b1; m_vec = {as_m, bs_m, qs_m};
        end
        check_at = -1;
      end else if (check_at >= 0) begin
        if (chg) check_at = cyc + S + 1;
      end else if (enable) begin
        if (chg) check_at = cyc + S + 1;
        else if (qs_m != pqs) begin
          m_e16 = sat_inc(m_e16, 65535); m_e2 = sat_inc(m_e2, 3);
          m_sticky = 1'b1; m_vec = {as_m, bs_m, qs_m};
        end
      end
      if (!enable) check_at = -1;
      if (clear) begin
        m_c16 = 0; m_e16 = 0; m_c2 = 0; m_e2 = 0; m_sticky = 1'b0; m_vec = 3'b000;
      end
      pab = {as_m, bs_m}; pqs = qs_m; pen = enable;
      s2 = s1; s1 = {a, b, q};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_in(input logic na, input logic nb, input logic nq);
    a = na; b = nb; q = nq;
  endtask

  int d0, f0;
  logic [1:0] walk [5];

  initial begin
    walk[0] = 2'b00; walk[1] = 2'b10; walk[2] = 2'b11; walk[3] = 2'b01; walk[4] = 2'b00;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    set_in(1'b0, 1'b0, 1'b1);
    step(3);
    chk("reset busy", int'(busy1), 0);
    chk("reset check_count", int'(cc1), 0);
    chk("reset fail_vec", int'(vec1), 0);

    // First check after reset with enable: steady 00 / q=1
    rst_n = 1'b1; enable = 1'b1;
    step(20);
    chk("first check count", int'(cc1), 1);
    chk("first error count", int'(ec1), 0);
    chk("first done pulses", ndone, 1);
    chk("model first count", m_c16, 1);

    // Walk of the truth table with a correct q
    foreach (walk[i]) begin
      set_in(walk[i][1], walk[i][0], !(walk[i][1] && walk[i][0]));
      step(20);
    end
    chk("walk check_count", int'(cc1), 5);
    chk("walk fail_sticky", int'(sticky1), 0);
    chk("w2 walk saturates", int'(cc2), 3);

    // Stuck-high output on 11
    set_in(1'b1, 1'b1, 1'b1);
    step(20);
    chk("mismatch error_count", int'(ec1), 1);
    chk("mismatch fail_vec", int'(vec1), 7);
    chk("mismatch sticky", int'(sticky1), 1);

    // Glitch on q while inputs hold
    set_in(1'b0, 1'b0, 1'b1);
    step(20);
    clear = 1'b1; step(1); clear = 1'b0;
    d0 = ndone;
    q = 1'b0; step(3); q = 1'b1; step(20);
    chk("glitch error_count", int'(ec1), 2);
    chk("glitch check_count", int'(cc1), 0);
    chk("glitch no done", ndone - d0, 0);
    chk("glitch fail_vec", int'(vec1), 1);

    // Fast toggling keeps the window open; one check after it stops
    d0 = ndone;
    for (int i = 0; i < 10; i++) begin
      a = ~a; step(2);
    end
    step(20);
    chk("toggle single done", ndone - d0, 1);

    // Clear in the very cycle of a failing check
    d0 = ndone; f0 = nfailp;
    set_in(1'b1, 1'b1, 1'b1);
    step(7);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("clear-vs-fail done seen", ndone - d0, 1);
    chk("clear-vs-fail fail seen", nfailp - f0, 1);
    chk("clear-vs-fail check_count", int'(cc1), 0);
    chk("clear-vs-fail error_count", int'(ec1), 0);
    chk("clear-vs-fail sticky", int'(sticky1), 0);
    set_in(1'b0, 1'b0, 1'b1);
    step(20);

    // Reset while a check is pending
    set_in(1'b1, 1'b0, 1'b1);
    step(4);
    chk("pre-reset busy", int'(busy1), 1);
    d0 = ndone;
    rst_n = 1'b0; step(1);
    chk("reset-abort busy", int'(busy1), 0);
    chk("reset-abort check_count", int'(cc1), 0);
    chk("reset-abort sticky", int'(sticky1), 0);
    chk("reset-abort done", ndone - d0, 0);
    rst_n = 1'b1;
    step(20);
    chk("post-reset check_count", int'(cc1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
